// File: rtl/girl10_out_checker.sv
`default_nettype none
// ============================================================================
// Module   : girl10_out_checker
// Brief    : Runtime checker for the girl10 controller outputs y1..y10.
//            Flags illegal output vectors and nonzero patterns held for
//            MAX_RUN sampled cycles, counts violations and latches an alarm.
//            Optional MISR signature output when GIRL10_OUT_CHECKER_SIG_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module girl10_out_checker #(
  parameter int MAX_RUN   = 8,
  parameter int CNT_W     = 8,
  parameter int ALARM_THR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y1,
  input  logic             y2,
  input  logic             y3,
  input  logic             y4,
  input  logic             y6,
  input  logic             y7,
  input  logic             y8,
  input  logic             y9,
  input  logic             y10,
  input  logic             en,
  input  logic             clr,
  output logic             illegal,
  output logic             stuck,
  output logic             alarm,
  output logic [CNT_W-1:0] evt_cnt,
  output logic [8:0]       last_bad
`ifdef GIRL10_OUT_CHECKER_SIG_EN
  ,
  output logic [15:0]      sig
`endif
);

  // Sum is one bit wider than the counter so saturation can be detected.
  localparam int                 SUM_W   = CNT_W + 1;
  localparam logic [SUM_W-1:0]   CNT_MAX = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0]   THR     = CNT_W'(ALARM_THR);
  localparam logic [7:0]         RUN_MAX = 8'(MAX_RUN);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MON   = 2'd1;
  localparam logic [1:0] ST_ALARM = 2'd2;

  // Membership test against the controller's legal output set.
  function automatic logic is_legal(input logic [8:0] vec);
    case (vec)
      9'h000, 9'h0C0, 9'h010, 9'h114, 9'h003,
      9'h00C, 9'h008, 9'h005, 9'h030: is_legal = 1'b1;
      default:                         is_legal = 1'b0;
    endcase
  endfunction

  logic [8:0]       v_w;
  logic [8:0]       v_q;
  logic             v_valid_q;
  logic [7:0]       run_q;
  logic [7:0]       run_d;
  logic             stuck_pend_q;
  logic             stuck_pend_d;
  logic             illegal_q;
  logic             stuck_q;
  logic [CNT_W-1:0] evt_cnt_q;
  logic [CNT_W-1:0] evt_cnt_d;
  logic [8:0]       last_bad_q;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             illegal_now;
  logic             stuck_now;
  logic [SUM_W-1:0] evt_sum;

  assign v_w = {y10, y9, y8, y7, y6, y4, y3, y2, y1};

  // Stage 1: capture the output vector; unaffected by clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q       <= 9'h000;
      v_valid_q <= 1'b0;
    end else begin
      if (en) begin
        v_q <= v_w;
      end
      v_valid_q <= en;
    end
  end

  // Run length of the incoming nonzero pattern; marks the first cycle it hits the limit.
  always_comb begin
    run_d        = 8'd0;
    stuck_pend_d = 1'b0;
    if (en && (v_w != 9'h000)) begin
      if (!v_valid_q || (v_w != v_q)) begin
        run_d = 8'd1;
      end else if (run_q >= RUN_MAX) begin
        run_d = RUN_MAX;
      end else begin
        run_d = run_q + 8'd1;
      end
    end
    // A restarted run is 1, so reaching RUN_MAX from below only happens on a continuing run.
    stuck_pend_d = (run_d == RUN_MAX) && (run_q != RUN_MAX);
  end

  // Run counter and pending stuck marker, cleared by clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q        <= 8'd0;
      stuck_pend_q <= 1'b0;
    end else if (clr) begin
      run_q        <= 8'd0;
      stuck_pend_q <= 1'b0;
    end else begin
      run_q        <= run_d;
      stuck_pend_q <= stuck_pend_d;
    end
  end

  // Stage 2 classification, saturating violation sum and alarm FSM next state.
  always_comb begin
    illegal_now = v_valid_q && !is_legal(v_q);
    stuck_now   = v_valid_q && stuck_pend_q;
    evt_sum     = {1'b0, evt_cnt_q} + SUM_W'(illegal_now) + SUM_W'(stuck_now);
    if (evt_sum > CNT_MAX) begin
      evt_cnt_d = CNT_MAX[CNT_W-1:0];
    end else begin
      evt_cnt_d = evt_sum[CNT_W-1:0];
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_MON;
        end
      end
      ST_MON: begin
        if (evt_cnt_d >= THR) begin
          state_d = ST_ALARM;
        end else if (!en) begin
          state_d = ST_IDLE;
        end
      end
      ST_ALARM: begin
        state_d = ST_ALARM;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stage 2 registers; clr wins over any coincident violation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_q  <= 1'b0;
      stuck_q    <= 1'b0;
      evt_cnt_q  <= '0;
      last_bad_q <= 9'h000;
      state_q    <= ST_IDLE;
    end else if (clr) begin
      illegal_q  <= 1'b0;
      stuck_q    <= 1'b0;
      evt_cnt_q  <= '0;
      last_bad_q <= 9'h000;
      state_q    <= ST_IDLE;
    end else begin
      illegal_q <= illegal_now;
      stuck_q   <= stuck_now;
      evt_cnt_q <= evt_cnt_d;
      if (illegal_now) begin
        last_bad_q <= v_q;
      end
      state_q <= state_d;
    end
  end

  assign illegal  = illegal_q;
  assign stuck    = stuck_q;
  assign alarm    = (state_q == ST_ALARM);
  assign evt_cnt  = evt_cnt_q;
  assign last_bad = last_bad_q;

`ifdef GIRL10_OUT_CHECKER_SIG_EN
  logic [15:0] sig_q;
  logic        sig_fb;

  assign sig_fb = sig_q[15] ^ sig_q[11] ^ sig_q[4];

  // Signature register compressing every valid sampled vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= 16'hFFFF;
    end else if (clr) begin
      sig_q <= 16'hFFFF;
    end else if (v_valid_q) begin
      sig_q <= {sig_q[14:0], sig_fb} ^ {7'b0, v_q};
    end
  end

  assign sig = sig_q;
`endif

endmodule
`default_nettype wire

// File: doc/girl10_out_checker.md
Name: girl10_out_checker

Overview:
- Downstream runtime checker for the girl10 controller's outputs y1..y10. It samples the controller's output vector once per cycle.
- Flags vectors outside the controller's legal output set, and flags nonzero patterns held too long.
- Counts violations and latches an alarm for the trojan-detection harness.

Parameters:
- MAX_RUN, 8: consecutive-cycle count of one identical nonzero pattern that raises stuck; legal range 2..255.
- CNT_W, 8: width of the violation counter; saturates at 2^CNT_W-1.
- ALARM_THR, 1: violation count at which alarm latches; range 1..2^CNT_W-1.

Ports:
- clk  in  1  clock; sampled on rising edge, the stable mid-cycle point of the controller's falling-edge state update.
- rst  in  1  asynchronous active-low reset.
- y1,y2,y3,y4,y6,y7,y8,y9,y10  in  1 each  controller outputs.
- en  in  1  sampling enable.
- clr  in  1  synchronous clear of counters, flags and alarm.
- illegal  out  1  one-cycle pulse: an illegal vector was seen.
- stuck  out  1  one-cycle pulse: run limit reached.
- alarm  out  1  latched alarm.
- evt_cnt  out  CNT_W  saturating violation count.
- last_bad  out  9  most recent illegal vector.

Behaviour:
- Vector v = {y10,y9,y8,y7,y6,y4,y3,y2,y1}, bit 0 = y1.
- Legal set: 0x000, 0x0C0, 0x010, 0x114, 0x003, 0x00C, 0x008, 0x005, 0x030. Every other value is illegal.
- Reset (rst=0, async): v_q=0, v_valid=0, run=0, illegal=0, stuck=0, alarm=0, evt_cnt=0, last_bad=0, FSM=IDLE.
- Stage 1 (edge k): if en=1, v_q<=v and v_valid<=1; otherwise v_valid<=0.
- Stage 2 (edge k+1): classify v_q when v_valid=1. The illegal and stuck outputs are registered, so latency is 2 edges from the sampling edge.
- Run counter, updated at stage 1:
  - run<=1 if v differs from v_q or v_valid=0; otherwise run<=run+1, saturating at MAX_RUN.
  - run<=0 when en=0 or v=0.
- Stuck fires once per run, on the cycle run first equals MAX_RUN, and never for 0x000. It does not refire until the pattern changes.
- Violations per cycle:
  - n = illegal_now + stuck_now (0..2).
  - evt_cnt<=min(evt_cnt+n, 2^CNT_W-1).
  - last_bad<=v_q when illegal_now.
- FSM:
  - IDLE: go to MON when en=1.
  - MON:
    - go to ALARM when updated evt_cnt >= ALARM_THR;
    - go to IDLE when en=0.
  - ALARM: alarm=1, held regardless of en; monitoring and counting continue. Leaves only on clr (to IDLE) or reset.
- clr=1 at an edge:
  - all registers take their reset values except v_q/v_valid, which sample normally;
  - clr wins over a coincident violation, whose count, pulse and last_bad update are dropped.
- en dropping mid-run: pipeline stops, counters and alarm hold, run clears. A pending stage-2 result from the last valid sample still completes.
- Reset asserted mid-operation: all outputs go to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: GIRL10_OUT_CHECKER_SIG_EN.
- Enabled:
  - adds output sig[15:0], a MISR over sampled vectors, seed 0xFFFF on reset and on clr;
  - on each edge with v_valid=1: sig<={sig[14:0],fb}^{7'b0,v_q}, where fb=sig[15]^sig[11]^sig[4];
  - sig holds when v_valid=0.
- Disabled: no sig port and no MISR logic; all other behaviour is identical.

Test Plan:
- Drive 0x0C0 x3, 0x003, 0x00C, 0x114 (all legal, en=1) -> illegal=0, stuck=0, evt_cnt=0, alarm=0.
- Drive 0x0C3 for one cycle (ALARM_THR=1) -> illegal high for exactly one cycle, 2 edges after sampling; last_bad=0x0C3, evt_cnt=1, alarm=1 and held after vectors return legal.
- MAX_RUN=8, hold 0x003 for 12 cycles -> exactly one stuck pulse, on the 8th sampled cycle, evt_cnt=1. Then hold 0x000 for 20 cycles -> no stuck.
- CNT_W=2, ALARM_THR=3, drive 5 isolated illegal vectors -> evt_cnt steps 1,2,3,3,3; alarm rises with the 3rd. Then apply clr coincident with a 6th illegal -> evt_cnt=0, alarm=0, last_bad=0, no illegal pulse.
- Drop rst low mid-run with alarm=1 and evt_cnt=2 -> all outputs 0 before the next clk edge. Release and drive 0x0C0 -> clean operation, no spurious pulses.
- With GIRL10_OUT_CHECKER_SIG_EN defined, one sampled 0x000 vector after reset -> sig=0xFFFF. Then a 0x003 vector -> sig=0xFFFC.
